block_header_buffer: RTL
========================

Name: block_header_buffer

Overview:
Receive-side packet-data stage between USB_rx_top_level and HM_top_level, instantiated inside the packet decoder.
- Collects payload bytes from the USB receiver into shadow registers.
- Validates payload length on eop and commits atomically to the data_to_hash / difficulty registers seen by the hasher.
- Pulses new_block once a complete work unit (data plus difficulty) is committed.
- Advances the nonce field on request from the main controller.

Parameters:
DATA_BYTES, 64, payload length of a DATA packet (data_to_hash width = 8*DATA_BYTES)
DIFF_BYTES, 32, payload length of a DIFFICULTY packet (difficulty width = 8*DIFF_BYTES)
NONCE_BITS, 32, width of nonce field at data_to_hash[NONCE_BITS-1:0]

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
write_enable  in  1  rx_data byte valid this cycle
rx_data  in  8  received payload byte
eop  in  1  end-of-packet strobe from USB receiver
pkt_sel  in  1  payload destination, sampled on first byte: 0 = DATA, 1 = DIFFICULTY
increment  in  1  advance nonce by 1
hash_done  in  1  hasher finished current block
data_to_hash  out  512  committed block data
difficulty  out  256  committed target
new_block  out  1  one-cycle pulse: full work unit committed
host_ready  out  1  buffer able to accept a new packet
p_error  out  1  one-cycle pulse: packet rejected
nonce_wrap  out  1  one-cycle pulse: nonce wrapped to 0

Behaviour:
- Reset values: all outputs 0 except host_ready = 1; byte count 0; state IDLE; have_data = have_diff = 0.
- Byte order is big-endian. Byte k of a packet lands at shadow bits [8*(N-k)-1 -: 8], so the first byte occupies the MSB.
- States:
  - IDLE: first write_enable latches pkt_sel, stores byte 0, count = 1, goes to LOAD.
  - LOAD: each write_enable stores a byte and increments count. A byte arriving with count == N (overflow) pulses p_error and goes to DISCARD. On eop, goes to CHECK.
  - DISCARD: ignores bytes; on eop, returns to IDLE.
  - CHECK (1 cycle): count == N → copy shadow to the committed register and set have_data or have_diff. Otherwise pulse p_error and leave committed registers unchanged. Always returns to IDLE with count = 0.
  - BUSY: entered from IDLE the cycle after a commit leaves have_data & have_diff both set. new_block pulses on the entry cycle. Stays until hash_done, then clears have_data and have_diff and returns to IDLE.
- N is DATA_BYTES or DIFF_BYTES according to the latched pkt_sel.
- An eop in IDLE with no bytes (zero-length packet) is ignored: no p_error.
- host_ready = 1 only in IDLE; 0 in LOAD, DISCARD, CHECK and BUSY. A write_enable arriving in BUSY pulses p_error and the byte is dropped.
- Nonce:
  - increment in BUSY adds 1 modulo 2^NONCE_BITS to data_to_hash[NONCE_BITS-1:0]; the result is visible the next cycle.
  - All-ones → 0 also pulses nonce_wrap.
  - increment outside BUSY is ignored.
  - increment coincident with hash_done is still applied.
- Commit and increment are never simultaneous, because commit occurs only in CHECK.
- write_enable and eop in the same cycle: the byte is stored first, then the length check includes it.
- Asynchronous reset mid-packet returns every register to its reset value.

Optional Feature:
CHECKSUM_EN
- Defined: each packet carries one extra trailing byte equal to the XOR of all payload bytes, so the expected length is N+1. CHECK additionally compares the running XOR with that byte; a mismatch pulses p_error and nothing is committed. The checksum byte is not stored.
- Undefined: no trailing byte, no XOR logic; length must be exactly N.

Decomposition:
- Package pd_pkg holds:
  - state enum hb_state_t {IDLE, LOAD, DISCARD, CHECK, BUSY};
  - constants PKT_DATA = 1'b0 and PKT_DIFF = 1'b1;
  - default byte counts.
- One sub-module, nonce_incrementer: registered NONCE_BITS adder with wrap pulse.

Test Plan:
- Reset, then a 64-byte DATA packet with bytes 0x00..0x3F followed by a 32-byte DIFF packet of 0xFF → data_to_hash[511:504] = 0x00 and [7:0] = 0x3F; difficulty all ones; a single new_block pulse; host_ready = 0 until hash_done.
- DATA packet of 63 bytes then eop → p_error for 1 cycle, data_to_hash unchanged, host_ready returns to 1.
- DATA packet of 65 bytes → p_error on byte 65; remaining bytes ignored until eop; no commit.
- Committed block with nonce 0xFFFFFFFE, two increment pulses → 0xFFFFFFFF, then 0x00000000 with one nonce_wrap pulse.
- write_enable during BUSY → p_error, committed registers unchanged; hash_done → host_ready = 1 the next cycle.
- CHECKSUM_EN defined: a correct XOR byte commits; a flipped checksum bit → p_error and no new_block.

Source files
------------

// File: rtl/block_header_buffer_pkg.sv
// Shared types and constants for the receive-side block header buffer.
package pd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DISCARD = 3'd2,
        CHECK   = 3'd3,
        BUSY    = 3'd4
    } hb_state_t;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_DIFF = 1'b1;

    localparam int unsigned DEF_DATA_BYTES = 64;
    localparam int unsigned DEF_DIFF_BYTES = 32;
    localparam int unsigned DEF_NONCE_BITS = 32;

endpackage

// File: rtl/block_header_buffer_if.sv
// Byte stream from the USB receiver into the block header buffer.
interface block_header_buffer_if;

    logic       write_enable;
    logic [7:0] rx_data;
    logic       eop;
    logic       pkt_sel;
    logic       host_ready;
    logic       p_error;

    modport master (
        output write_enable, rx_data, eop, pkt_sel,
        input  host_ready, p_error
    );

    modport slave (
        input  write_enable, rx_data, eop, pkt_sel,
        output host_ready, p_error
    );

endinterface

// File: rtl/block_header_buffer_nonce_incrementer.sv
// Nonce register: loaded on a data commit, advanced by one on request,
// with a one-cycle wrap pulse when all-ones rolls over to zero.
module nonce_incrementer #(
    parameter int unsigned NONCE_BITS = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic [NONCE_BITS-1:0] load_value,
    input  logic                  inc,
    output logic [NONCE_BITS-1:0] nonce,
    output logic                  wrap
);

    // load has priority; load and inc never coincide in normal operation
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nonce <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                nonce <= load_value;
            end else if (inc) begin
                nonce <= nonce + NONCE_BITS'(1);
                wrap  <= &nonce;
            end
        end
    end

endmodule

// File: rtl/block_header_buffer.sv
// Block header buffer: collects DATA / DIFFICULTY payload bytes into a
// shadow register, commits on a valid length at eop, pulses new_block
// when both halves of a work unit are present, and advances the nonce.
// Optional macro CHECKSUM_EN: a trailing XOR byte is expected and checked.
module block_header_buffer
    import pd_pkg::*;
#(
    parameter int unsigned DATA_BYTES = DEF_DATA_BYTES,
    parameter int unsigned DIFF_BYTES = DEF_DIFF_BYTES,
    parameter int unsigned NONCE_BITS = DEF_NONCE_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    block_header_buffer_if.slave    bus,
    input  logic                    increment,
    input  logic                    hash_done,
    output logic [8*DATA_BYTES-1:0] data_to_hash,
    output logic [8*DIFF_BYTES-1:0] difficulty,
    output logic                    new_block,
    output logic                    nonce_wrap
);

    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned CNT_W = $clog2(DATA_BYTES + 3);
`ifdef CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    hb_state_t              state;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       len_n;
    logic [CNT_W-1:0]       len_total;
    logic                   sel;
    logic                   have_data;
    logic                   have_diff;
    logic                   p_error_q;
    logic [DW-1:0]          shadow;
    logic [DW-1:0]          shadow_next;
    logic [DW-NONCE_BITS-1:0] data_hi;
    logic [NONCE_BITS-1:0]  nonce;
    logic                   idle_take;
    logic                   load_take;
    logic                   store_payload;
    logic                   cks_ok;
    logic                   commit_ok;
    logic                   load_nonce;
    logic                   nonce_inc;

    // Expected length and byte-acceptance decode. Bytes shift in from the
    // LSB, so after N bytes the first byte sits at the top of the N-byte field.
    always_comb begin
        len_n         = (sel == PKT_DIFF) ? CNT_W'(DIFF_BYTES) : CNT_W'(DATA_BYTES);
        len_total     = len_n + CNT_W'(EXTRA);
        shadow_next   = {shadow[DW-9:0], bus.rx_data};
        idle_take     = (state == IDLE) && !(have_data && have_diff) && bus.write_enable;
        load_take     = (state == LOAD) && bus.write_enable && (count != len_total);
        store_payload = idle_take || (load_take && (count < len_n));
    end

`ifdef CHECKSUM_EN
    logic [7:0] xor_acc;
    logic [7:0] cks_byte;

    // Running XOR of payload bytes and capture of the trailing checksum byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            xor_acc  <= '0;
            cks_byte <= '0;
        end else if (idle_take) begin
            xor_acc <= bus.rx_data;
        end else if (load_take) begin
            if (count < len_n)
                xor_acc <= xor_acc ^ bus.rx_data;
            else
                cks_byte <= bus.rx_data;
        end
    end

    assign cks_ok = (xor_acc == cks_byte);
`else
    assign cks_ok = 1'b1;
`endif

    assign commit_ok  = (state == CHECK) && (count == len_total) && cks_ok;
    assign load_nonce = commit_ok && (sel == PKT_DATA);
    assign nonce_inc  = (state == BUSY) && increment;

    // Packet state machine, shadow capture and atomic commit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            count      <= '0;
            sel        <= PKT_DATA;
            shadow     <= '0;
            data_hi    <= '0;
            difficulty <= '0;
            have_data  <= 1'b0;
            have_diff  <= 1'b0;
            p_error_q  <= 1'b0;
            new_block  <= 1'b0;
        end else begin
            p_error_q <= 1'b0;
            new_block <= 1'b0;
            if (store_payload)
                shadow <= shadow_next;
            case (state)
                IDLE: begin
                    // a complete work unit takes priority over a new packet
                    if (have_data && have_diff) begin
                        state     <= BUSY;
                        new_block <= 1'b1;
                        p_error_q <= bus.write_enable;
                    end else if (bus.write_enable) begin
                        sel   <= bus.pkt_sel;
                        count <= CNT_W'(1);
                        state <= bus.eop ? CHECK : LOAD;
                    end
                end
                LOAD: begin
                    if (bus.write_enable && (count == len_total)) begin
                        p_error_q <= 1'b1;
                        count     <= '0;
                        state     <= bus.eop ? IDLE : DISCARD;
                    end else begin
                        if (bus.write_enable)
                            count <= count + CNT_W'(1);
                        if (bus.eop)
                            state <= CHECK;
                    end
                end
                DISCARD: begin
                    if (bus.eop)
                        state <= IDLE;
                end
                CHECK: begin
                    if (commit_ok) begin
                        if (sel == PKT_DATA) begin
                            data_hi   <= shadow[DW-1:NONCE_BITS];
                            have_data <= 1'b1;
                        end else begin
                            difficulty <= shadow[8*DIFF_BYTES-1:0];
                            have_diff  <= 1'b1;
                        end
                    end else begin
                        p_error_q <= 1'b1;
                    end
                    count <= '0;
                    state <= IDLE;
                end
                BUSY: begin
                    p_error_q <= bus.write_enable;
                    if (hash_done) begin
                        have_data <= 1'b0;
                        have_diff <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    nonce_incrementer #(
        .NONCE_BITS (NONCE_BITS)
    ) u_nonce (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (load_nonce),
        .load_value (shadow[NONCE_BITS-1:0]),
        .inc        (nonce_inc),
        .nonce      (nonce),
        .wrap       (nonce_wrap)
    );

    assign data_to_hash   = {data_hi, nonce};
    assign bus.host_ready = (state == IDLE);
    assign bus.p_error    = p_error_q;

endmodule
